apb_uart_tx: RTL and testbench
==============================

// Module: apb_uart_tx
// PURPOSE
//   APB3 slave UART transmitter (8N1, LSB first) with a byte FIFO and programmable baud divider.
//   Attaches to the APB mux as an extra slave next to dmem/switch/LED/timer.
//   The CPU streams bytes into it over APB; it serialises them onto o_tx.
//   Raises o_irq when all queued data has been sent.
// PARAMETERS
//   FIFO_DEPTH   8    TX FIFO entries (power of 2, >=2)
//   DEFAULT_DIV  433  BAUDDIV reset value; bit period = BAUDDIV+1 PCLK cycles
// PORTS
//   PCLK      in   1   single clock; every flop is on its rising edge
//   PRESETn   in   1   asynchronous active-low reset
//   PSEL      in   1   APB select
//   PENABLE   in   1   APB access phase
//   PWRITE    in   1   1=write, 0=read
//   PADDR     in   32  byte address; only PADDR[3:2] decoded
//   PWDATA    in   32  write data
//   PRDATA    out  32  read data
//   PREADY    out  1   tied 1 (zero wait states)
//   o_tx      out  1   serial line, idle high
//   o_irq     out  1   level interrupt
// BEHAVIOUR
//   Registers (PADDR[3:2]):
//     0 TXDATA  W: push PWDATA[7:0] into FIFO; R: 0
//     1 STATUS  R: [0]busy [1]full [2]empty [3]ovf(sticky); W: 1 to bit3 clears ovf
//     2 BAUDDIV RW [15:0]; 0 is treated as 1 (minimum 2 cycles/bit)
//     3 CTRL    RW [0]tx_en [1]irq_en; reset 0
//   Unused bits read 0. Writes to reserved bits are ignored.
//   Write strobe = PSEL&PENABLE&PWRITE; commits on that PCLK edge.
//   Read: PRDATA combinational when PSEL&!PWRITE; 0 otherwise.
//   Reset (async): o_tx=1, o_irq=0, FIFO emptied, ovf=0, CTRL=0, BAUDDIV=DEFAULT_DIV, FSM=IDLE.
//   FIFO: push when full -> byte dropped, ovf<=1.
//     Push and pop in the same cycle: allowed if not full; count unchanged.
//   FSM states IDLE, START, DATA, STOP; baud counter bcnt, bit index bidx[2:0].
//     IDLE: if tx_en & !empty -> pop head into shift reg, latch div=BAUDDIV, go to START next edge.
//     START: o_tx=0 for div+1 cycles -> DATA, bidx=0.
//     DATA: o_tx=shift[bidx] for div+1 cycles; after bidx==7 -> STOP.
//     STOP: o_tx=1 for div+1 cycles. Then:
//       - if tx_en & !empty, pop and go directly to START (no idle gap);
//       - otherwise go to IDLE.
//   o_tx is driven from a flop (glitch-free).
//   Frame length = 10*(div+1) cycles; first START cycle is 1 cycle after the pop decision edge.
//   BAUDDIV writes mid-frame do not affect the current frame (div latched at pop).
//   Clearing tx_en mid-frame: current frame completes; no further pops.
//   busy = (FSM != IDLE).
//   o_irq = irq_en & empty & !busy (registered, 1-cycle latency).
//   Reset asserted mid-frame: o_tx goes high immediately; queued data is lost.
// TESTING
//   Reset -> o_tx=1, STATUS=0x4, BAUDDIV=433, CTRL=0, o_irq=0.
//   BAUDDIV=3, CTRL=1, TXDATA=0x55 -> o_tx: 0 x4, then 1,0,1,0,1,0,1,0 x4 each, then 1 x4; 40 cycles total; busy high throughout.
//   CTRL=0, push 9 bytes -> STATUS full=1, ovf=1; then CTRL=1 -> exactly 8 bytes sent; W1C STATUS bit3 -> ovf=0.
//   BAUDDIV=1, CTRL=1, push 0xA3 and 0x0F back-to-back -> second start bit directly follows first stop bit; 40 cycles total.
//   CTRL=3, push 0x00 -> o_irq=0 while sending; o_irq=1 one cycle after return to IDLE; CTRL=1 -> o_irq=0.
//   Assert PRESETn low mid-DATA with 3 bytes queued -> o_tx=1 asynchronously; after release STATUS=0x4, no further output.

Source files
------------

// File: rtl/apb_uart_tx.sv
// APB3 slave UART transmitter: 8N1, LSB first, byte FIFO, programmable baud divider.
// Registers live at PADDR[3:2]: TXDATA, STATUS, BAUDDIV, CTRL. Zero wait states.
`timescale 1ns / 1ps

module apb_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 433
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] AddrTxData  = 2'd0;
  localparam logic [1:0] AddrStatus  = 2'd1;
  localparam logic [1:0] AddrBaudDiv = 2'd2;
  localparam logic [1:0] AddrCtrl    = 2'd3;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // APB decode
  logic       wr_en;
  logic [1:0] reg_addr;
  logic       push_req;
  logic       ovf_clr;

  // Control / status registers
  logic [15:0] baud_q;
  logic        tx_en_q;
  logic        irq_en_q;
  logic        ovf_q;
  logic        irq_q;

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [7:0]      fifo_head;

  // Serialiser
  state_e      state_q;
  logic        tx_q;
  logic [15:0] bcnt_q;
  logic [15:0] div_q;
  logic [2:0]  bidx_q;
  logic [2:0]  bidx_nxt;
  logic [7:0]  shift_q;
  logic [15:0] div_eff;
  logic        bit_done;
  logic        busy;

  // Only PADDR[3:2] and the low data bits are architecturally meaningful
  logic unused_bits;
  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

  assign wr_en    = PSEL & PENABLE & PWRITE;
  assign reg_addr = PADDR[3:2];
  assign push_req = wr_en & (reg_addr == AddrTxData);
  assign ovf_clr  = wr_en & (reg_addr == AddrStatus) & PWDATA[3];

  assign PREADY = 1'b1;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped even if a pop happens on the same edge
  assign push = push_req & ~fifo_full;

  // BAUDDIV of 0 would give a 1-cycle bit; clamp to the 2-cycle minimum
  assign div_eff  = (baud_q == 16'd0) ? 16'd1 : baud_q;
  assign bit_done = (bcnt_q == div_q);
  assign bidx_nxt = bidx_q + 3'd1;
  assign busy     = (state_q != StIdle);

  // Pop when idle, or at the very end of a stop bit so frames run back to back
  assign pop = tx_en_q & ~fifo_empty &
               ((state_q == StIdle) | ((state_q == StStop) & bit_done));

  // Software-visible configuration and the sticky overflow flag
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      baud_q   <= 16'(DEFAULT_DIV);
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_addr)
          AddrBaudDiv: baud_q <= PWDATA[15:0];
          AddrCtrl: begin
            tx_en_q  <= PWDATA[0];
            irq_en_q <= PWDATA[1];
          end
          default: ;
        endcase
      end
      if (push_req & fifo_full) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset since the count gates every read
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= PWDATA[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

  // Frame serialiser; o_tx comes straight from tx_q so the line never glitches
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      tx_q    <= 1'b1;
      bcnt_q  <= '0;
      div_q   <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_head;
            div_q   <= div_eff;
            bcnt_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_done) begin
            bcnt_q  <= '0;
            bidx_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            bcnt_q <= bcnt_q + 16'd1;
          end
        end
        StData: begin
          if (bit_done) begin
            bcnt_q <= '0;
            if (bidx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bidx_q <= bidx_nxt;
              tx_q   <= shift_q[bidx_nxt];
            end
          end else begin
            bcnt_q <= bcnt_q + 16'd1;
          end
        end
        StStop: begin
          if (bit_done) begin
            bcnt_q <= '0;
            if (pop) begin
              shift_q <= fifo_head;
              div_q   <= div_eff;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              tx_q    <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            bcnt_q <= bcnt_q + 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Level interrupt: everything queued has left the wire
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en_q & fifo_empty & ~busy;
    end
  end

  assign o_tx  = tx_q;
  assign o_irq = irq_q;

  // Read mux; TXDATA reads as zero
  always_comb begin
    PRDATA = 32'd0;
    if (PSEL & ~PWRITE) begin
      case (reg_addr)
        AddrStatus:  PRDATA = {28'd0, ovf_q, fifo_empty, fifo_full, busy};
        AddrBaudDiv: PRDATA = {16'd0, baud_q};
        AddrCtrl:    PRDATA = {30'd0, irq_en_q, tx_en_q};
        default:     PRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Directed bench for apb_uart_tx: reset values, frame waveforms, FIFO overflow,
// back-to-back frames, interrupt timing and asynchronous reset mid-frame.
`timescale 1ns / 1ps

module tb_apb_uart_tx;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        o_tx;
  logic        o_irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_bytes[$];

  apb_uart_tx #(
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(433)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .o_tx   (o_tx),
    .o_irq  (o_irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Between accesses the bus sits on a STATUS read so busy is visible on PRDATA
  task automatic park_bus();
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = 32'h4;
    PWDATA  = 32'h0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    PADDR   = addr;
    PWDATA  = data;
    PWRITE  = 1'b1;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    park_bus();
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    PADDR   = addr;
    PWRITE  = 1'b0;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    data = PRDATA;
    @(posedge PCLK); #1;
    park_bus();
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge PCLK);
      if (o_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Compare o_tx cycle by cycle against the frames for exp_bytes, per cycles per bit
  task automatic run_stream(input string tag, input int per, input bit chk_busy);
    bit   ok;
    int   n;
    int   bad_tx;
    int   bad_busy;
    int   bad_irq;
    logic exp;
    wait_start(ok);
    check_eq({tag, "_start"}, 32'(ok), 32'd1);
    if (!ok) return;
    n        = 0;
    bad_tx   = 0;
    bad_busy = 0;
    bad_irq  = 0;
    foreach (exp_bytes[f]) begin
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < per; c++) begin
          if (n > 0) @(negedge PCLK);
          if (k == 0) exp = 1'b0;
          else if (k == 9) exp = 1'b1;
          else exp = exp_bytes[f][k-1];
          if (o_tx !== exp) bad_tx++;
          if (chk_busy && PRDATA[0] !== 1'b1) bad_busy++;
          if (o_irq !== 1'b0) bad_irq++;
          n++;
        end
      end
    end
    check_eq({tag, "_bit_errors"}, 32'(bad_tx), 32'd0);
    check_eq({tag, "_irq_while_busy"}, 32'(bad_irq), 32'd0);
    if (chk_busy) check_eq({tag, "_busy_gaps"}, 32'(bad_busy), 32'd0);
    @(negedge PCLK);
    check_eq({tag, "_line_idle"}, 32'(o_tx), 32'd1);
    check_eq({tag, "_irq_at_idle"}, 32'(o_irq), 32'd0);
    if (chk_busy) check_eq({tag, "_busy_end"}, 32'(PRDATA[0]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    bit          ok;

    PRESETn = 1'b0;
    park_bus();
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // Reset values
    @(negedge PCLK);
    check_eq("rst_tx", 32'(o_tx), 32'd1);
    check_eq("rst_irq", 32'(o_irq), 32'd0);
    check_eq("rst_pready", 32'(PREADY), 32'd1);
    apb_read(32'h4, rd);
    check_eq("rst_status", rd, 32'h4);
    apb_read(32'h8, rd);
    check_eq("rst_bauddiv", rd, 32'd433);
    apb_read(32'hC, rd);
    check_eq("rst_ctrl", rd, 32'h0);
    apb_read(32'h0, rd);
    check_eq("txdata_reads_zero", rd, 32'h0);

    // Single 0x55 frame at 4 cycles per bit
    apb_write(32'h8, 32'd3);
    apb_read(32'h8, rd);
    check_eq("bauddiv_rw", rd, 32'd3);
    apb_write(32'hC, 32'h1);
    exp_bytes = {8'h55};
    apb_write(32'h0, 32'h55);
    run_stream("frame55", 4, 1'b1);

    // Overflow: nine pushes with transmit disabled, only eight survive
    apb_write(32'h8, 32'd1);
    apb_write(32'hC, 32'h0);
    for (int i = 0; i < 9; i++) apb_write(32'h0, 32'(8'h10 + i));
    apb_read(32'h4, rd);
    check_eq("ovf_status_full", rd, 32'hA);
    exp_bytes = {};
    for (int i = 0; i < 8; i++) exp_bytes.push_back(8'(8'h10 + i));
    apb_write(32'hC, 32'h1);
    run_stream("ovf_drain", 2, 1'b1);
    wait_start(ok);
    check_eq("ovf_no_ninth", 32'(ok), 32'd0);
    apb_read(32'h4, rd);
    check_eq("ovf_sticky", rd, 32'hC);
    apb_write(32'h4, 32'h8);
    apb_read(32'h4, rd);
    check_eq("ovf_w1c", rd, 32'h4);

    // Back-to-back: second start bit directly follows first stop bit
    exp_bytes = {8'hA3, 8'h0F};
    fork
      begin
        apb_write(32'h0, 32'hA3);
        apb_write(32'h0, 32'h0F);
      end
      run_stream("b2b", 2, 1'b0);
    join

    // BAUDDIV of 0 behaves as 1
    apb_write(32'h8, 32'd0);
    exp_bytes = {8'hC6};
    apb_write(32'h0, 32'hC6);
    run_stream("div0", 2, 1'b1);

    // Interrupt: low while sending, high one cycle after returning to idle
    apb_write(32'h8, 32'd1);
    apb_write(32'hC, 32'h3);
    exp_bytes = {8'h00};
    apb_write(32'h0, 32'h00);
    run_stream("irq", 2, 1'b1);
    @(negedge PCLK);
    check_eq("irq_rise", 32'(o_irq), 32'd1);
    apb_write(32'hC, 32'h1);
    @(negedge PCLK);
    @(negedge PCLK);
    check_eq("irq_disable", 32'(o_irq), 32'd0);

    // Asynchronous reset in the middle of a data bit with three bytes queued
    apb_write(32'hC, 32'h0);
    apb_write(32'h8, 32'd3);
    for (int i = 0; i < 3; i++) apb_write(32'h0, 32'h00);
    apb_write(32'hC, 32'h1);
    wait_start(ok);
    check_eq("arst_start", 32'(ok), 32'd1);
    repeat (6) @(negedge PCLK);
    check_eq("arst_pre_tx", 32'(o_tx), 32'd0);
    #2 PRESETn = 1'b0;
    #1;
    check_eq("arst_tx_async", 32'(o_tx), 32'd1);
    check_eq("arst_status_in_reset", PRDATA, 32'h4);
    @(posedge PCLK);
    #3 PRESETn = 1'b1;
    wait_start(ok);
    check_eq("arst_no_output", 32'(ok), 32'd0);
    apb_read(32'h4, rd);
    check_eq("arst_status", rd, 32'h4);
    apb_read(32'hC, rd);
    check_eq("arst_ctrl", rd, 32'h0);
    apb_read(32'h8, rd);
    check_eq("arst_bauddiv", rd, 32'd433);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
